// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and lane helpers for the load/store unit
package lsu_pkg;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD} lsu_size_e;
    typedef enum logic [2:0] {ST_IDLE, ST_READ, ST_WAIT, ST_WRITE, ST_RESP} lsu_state_e;
    localparam int WORD_BYTES = 4;

    function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] lane);
        return (size == SZ_RSVD) || (size == SZ_HALF && lane[0]) || (size == SZ_WORD && lane != 2'b00);
    endfunction

    function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] lane,
                                                 input lsu_size_e size, input logic uns);
        logic [7:0]  w_b;
        logic [15:0] w_h;
        w_b = word[{lane, 3'b000} +: 8];
        w_h = lane[1] ? word[31:16] : word[15:0];
        return size == SZ_BYTE ? {{24{w_b[7] & ~uns}}, w_b} :
               size == SZ_HALF ? {{16{w_h[15] & ~uns}}, w_h} : word;
    endfunction

    function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [31:0] wdata,
                                                input logic [1:0] lane, input lsu_size_e size);
        logic [31:0] w_mask;
        w_mask = (size == SZ_BYTE ? 32'h0000_00FF : size == SZ_HALF ? 32'h0000_FFFF : 32'hFFFF_FFFF)
                 << {lane, 3'b000};
        return (word & ~w_mask) | ((wdata << {lane, 3'b000}) & w_mask);
    endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational load lane extract/extend and sub-word store merge
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_lane,
    input  lsu_size_e   i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_load,
    output logic [31:0] o_merge
);
    assign o_load  = extract_load(i_word, i_lane, i_size, i_unsigned);
    assign o_merge = merge_store(i_word, i_wdata, i_lane, i_size);
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store initiator turning sub-word requests into aligned word accesses.
// Define LSU_STATS_EN to add saturating load/store/error response counters.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [1:0]        i_req_size,
    input  logic              i_req_unsigned,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [31:0]       i_req_wdata,
    output logic              o_rsp_valid,
    output logic [31:0]       o_rsp_rdata,
    output logic              o_rsp_err,
`ifdef LSU_STATS_EN
    output logic [CNT_W-1:0]  o_load_cnt,
    output logic [CNT_W-1:0]  o_store_cnt,
    output logic [CNT_W-1:0]  o_err_cnt,
`endif
    output logic [ADDR_W-1:0] o_A,
    output logic [31:0]       o_WD,
    output logic              o_WE,
    input  logic [31:0]       i_RD
);
    lsu_state_e  r_state;
    logic        r_we;
    lsu_size_e   r_size;
    logic        r_uns;
    logic [1:0]  r_lane;
    logic [31:0] r_wdata;
    logic [31:0] w_load;
    logic [31:0] w_merge;
    lsu_size_e   w_size;
    logic        w_mis;

    assign w_size      = lsu_size_e'(i_req_size);
    assign w_mis       = is_misaligned(w_size, i_req_addr[1:0]);
    assign o_req_ready = r_state == ST_IDLE;
    assign o_rsp_valid = r_state == ST_RESP;
    // Decoded from state so reset drops the write strobe without waiting for a clock
    assign o_WE        = r_state == ST_WRITE;

    lsu_lane_align u_align (
        .i_word    (i_RD),
        .i_wdata   (r_wdata),
        .i_lane    (r_lane),
        .i_size    (r_size),
        .i_unsigned(r_uns),
        .o_load    (w_load),
        .o_merge   (w_merge)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_we        <= 1'b0;
            r_size      <= SZ_BYTE;
            r_uns       <= 1'b0;
            r_lane      <= 2'b00;
            r_wdata     <= '0;
            o_rsp_err   <= 1'b0;
            o_rsp_rdata <= '0;
            o_A         <= '0;
            o_WD        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (i_req_valid) begin
                    r_we        <= i_req_we;
                    r_size      <= w_size;
                    r_uns       <= i_req_unsigned;
                    r_lane      <= i_req_addr[1:0];
                    r_wdata     <= i_req_wdata;
                    o_rsp_err   <= w_mis;
                    o_rsp_rdata <= '0;
                    if (w_mis) begin
                        r_state <= ST_RESP;
                    end else begin
                        o_A <= {i_req_addr[ADDR_W-1:2], 2'b00};
                        if (i_req_we && w_size == SZ_WORD) begin
                            o_WD    <= i_req_wdata;
                            r_state <= ST_WRITE;
                        end else begin
                            r_state <= ST_READ;
                        end
                    end
                end
                ST_READ: r_state <= ST_WAIT;
                ST_WAIT: begin
                    if (r_we) o_WD <= w_merge;
                    else o_rsp_rdata <= w_load;
                    r_state <= r_we ? ST_WRITE : ST_RESP;
                end
                ST_WRITE: r_state <= ST_RESP;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef LSU_STATS_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_load_cnt  <= '0;
            o_store_cnt <= '0;
            o_err_cnt   <= '0;
        end else if (r_state == ST_RESP) begin
            if (o_rsp_err) o_err_cnt <= o_err_cnt + CNT_W'(~&o_err_cnt);
            else if (r_we) o_store_cnt <= o_store_cnt + CNT_W'(~&o_store_cnt);
            else o_load_cnt <= o_load_cnt + CNT_W'(~&o_load_cnt);
        end
    end
`endif
endmodule
